// File: rtl/biassram_r.sv
// Bias SRAM read stage: fetches bias[0]/bias[1] on start, then serves one bias per next request.
// Optional BIAS_RD_WRAP_EN keeps the block serving and wraps the read pointer for per-tile reuse.
module biassram_r #(
  parameter int BIAS_ST_LENGTH = 64,
  parameter int ADDR_CNT_BITS  = 9,
  parameter int BIAS_SRAM_WLEN = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bias_rd1st_start,
  output logic                      bias_rd1st_busy,
  output logic                      bias_rd1st_done,
  output logic                      cen_biasr_rd,
  output logic                      wen_biasr_rd,
  output logic [ADDR_CNT_BITS-1:0]  addr_biasr_rd,
  input  logic [BIAS_SRAM_WLEN-1:0] dout_biasr_0,
  output logic [BIAS_SRAM_WLEN-1:0] bias_out,
  output logic                      bias_valid,
  input  logic                      bias_next,
  output logic                      bias_layer_end
);

  typedef enum logic [1:0] {IDLE, RD0, RD1, SERVE} state_t;

  localparam logic [ADDR_CNT_BITS-1:0] LAST = ADDR_CNT_BITS'(BIAS_ST_LENGTH - 1);

  state_t                    state;
  logic [ADDR_CNT_BITS-1:0]  rd_ptr;
  logic [ADDR_CNT_BITS-1:0]  cons_cnt;
  logic [BIAS_SRAM_WLEN-1:0] pf_data;
  logic                      pf_valid;
  logic                      land;
  logic                      rd_done;
  logic                      accept;

  assign accept = (state == SERVE) && bias_next && bias_valid;

  // land marks the cycle in which dout carries the word requested one cycle earlier
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      bias_rd1st_busy <= 1'b0;
      bias_rd1st_done <= 1'b0;
      bias_valid      <= 1'b0;
      bias_layer_end  <= 1'b0;
      cen_biasr_rd    <= 1'b1;
      wen_biasr_rd    <= 1'b1;
      addr_biasr_rd   <= '0;
      bias_out        <= '0;
      pf_data         <= '0;
      pf_valid        <= 1'b0;
      rd_ptr          <= '0;
      cons_cnt        <= '0;
      rd_done         <= 1'b0;
      land            <= 1'b0;
    end else begin
      bias_rd1st_done <= 1'b0;
      bias_layer_end  <= 1'b0;
      wen_biasr_rd    <= 1'b1;
      land            <= ~cen_biasr_rd;
      case (state)
        IDLE: begin
          if (bias_rd1st_start) begin
            state           <= RD0;
            bias_rd1st_busy <= 1'b1;
            cen_biasr_rd    <= 1'b0;
            addr_biasr_rd   <= '0;
          end
        end
        RD0: begin
          state         <= RD1;
          cen_biasr_rd  <= 1'b0;
          addr_biasr_rd <= ADDR_CNT_BITS'(1);
        end
        RD1: begin
          state           <= SERVE;
          cen_biasr_rd    <= 1'b1;
          bias_out        <= dout_biasr_0;
          bias_valid      <= 1'b1;
          bias_rd1st_done <= 1'b1;
          pf_valid        <= 1'b0;
          cons_cnt        <= '0;
          rd_ptr          <= (LAST == ADDR_CNT_BITS'(1)) ? '0 : ADDR_CNT_BITS'(2);
`ifdef BIAS_RD_WRAP_EN
          rd_done         <= 1'b0;
`else
          rd_done         <= (LAST == ADDR_CNT_BITS'(1));
`endif
        end
        SERVE: begin
          cen_biasr_rd <= 1'b1;
          // Buffer move: a landing word fills whichever slot is free after this edge's consume
          if (accept && pf_valid) begin
            bias_out <= pf_data;
            pf_valid <= land;
            if (land) pf_data <= dout_biasr_0;
          end else if (accept) begin
            bias_valid <= land;
            if (land) bias_out <= dout_biasr_0;
          end else if (land) begin
            if (bias_valid) begin
              pf_data  <= dout_biasr_0;
              pf_valid <= 1'b1;
            end else begin
              bias_out   <= dout_biasr_0;
              bias_valid <= 1'b1;
            end
          end
          if (accept && !rd_done) begin
            cen_biasr_rd  <= 1'b0;
            addr_biasr_rd <= rd_ptr;
            if (rd_ptr == LAST) begin
              rd_ptr <= '0;
`ifndef BIAS_RD_WRAP_EN
              rd_done <= 1'b1;
`endif
            end else begin
              rd_ptr <= rd_ptr + 1'b1;
            end
          end
          if (accept) begin
            if (cons_cnt == LAST) begin
              cons_cnt       <= '0;
              bias_layer_end <= 1'b1;
`ifndef BIAS_RD_WRAP_EN
              state           <= IDLE;
              bias_rd1st_busy <= 1'b0;
              bias_valid      <= 1'b0;
              pf_valid        <= 1'b0;
`endif
            end else begin
              cons_cnt <= cons_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_biassram_r.sv
// Self-checking bench for biassram_r with a 1-cycle-latency SRAM model and BIAS_ST_LENGTH=4.
// Define BIAS_RD_WRAP_EN for both bench and RTL to exercise the wrap-around build.
module tb_biassram_r;

  localparam int LEN = 4;
  localparam int AW  = 9;
  localparam int DW  = 32;
`ifdef BIAS_RD_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          next = 1'b0;
  logic          busy, done, cen, wen, valid, layer_end;
  logic [AW-1:0] addr;
  logic [DW-1:0] dout = '0;
  logic [DW-1:0] bias_out;

  logic [DW-1:0] mem [LEN];
  int            rd_q[$];
  int            tests = 0;
  int            fails = 0;

  biassram_r #(.BIAS_ST_LENGTH(LEN), .ADDR_CNT_BITS(AW), .BIAS_SRAM_WLEN(DW)) dut (
    .clk(clk), .reset(reset), .bias_rd1st_start(start), .bias_rd1st_busy(busy),
    .bias_rd1st_done(done), .cen_biasr_rd(cen), .wen_biasr_rd(wen), .addr_biasr_rd(addr),
    .dout_biasr_0(dout), .bias_out(bias_out), .bias_valid(valid), .bias_next(next),
    .bias_layer_end(layer_end)
  );

  always #5 clk = ~clk;

  // SRAM model and read-address log
  always @(posedge clk) if (!cen) dout <= mem[addr[1:0]];
  always @(negedge clk) if (!cen) rd_q.push_back(int'(addr));

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; next = 1'b0;
    step(); step();
    reset = 1'b0;
    rd_q.delete();
  endtask

  task automatic preload_fixed();
    for (int i = 0; i < LEN; i++) mem[i] = 32'h10 + i;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 8 && done !== 1'b1; i++) step();
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("[TB] FAIL wait_done: got done=%b required 1 within 8 cycles", done);
    end
  endtask

  task automatic test_reset();
    preload_fixed();
    do_reset();
    tests++;
    if ({busy, done, valid, layer_end, cen, wen} !== 6'b000011) begin
      fails++;
      $display("[TB] FAIL reset_ctrl: got %b required 000011", {busy, done, valid, layer_end, cen, wen});
    end
    tests++;
    if (addr !== '0 || bias_out !== '0) begin
      fails++;
      $display("[TB] FAIL reset_data: got addr=%h bias=%h required 0/0", addr, bias_out);
    end
  endtask

  task automatic test_first_read();
    start = 1'b1; step(); start = 1'b0;
    tests++;
    if ({busy, cen, addr} !== {1'b1, 1'b0, 9'd0}) begin
      fails++;
      $display("[TB] FAIL rd0: got busy=%b cen=%b addr=%0d required 1/0/0", busy, cen, addr);
    end
    step();
    tests++;
    if ({cen, addr, done} !== {1'b0, 9'd1, 1'b0}) begin
      fails++;
      $display("[TB] FAIL rd1: got cen=%b addr=%0d done=%b required 0/1/0", cen, addr, done);
    end
    step();
    tests++;
    if (done !== 1'b1 || valid !== 1'b1 || bias_out !== 32'h10 || cen !== 1'b1) begin
      fails++;
      $display("[TB] FAIL first_done: got done=%b valid=%b bias=%h cen=%b required 1/1/10/1",
               done, valid, bias_out, cen);
    end
    step();
    tests++;
    if (done !== 1'b0 || valid !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL done_pulse: got done=%b valid=%b busy=%b required 0/1/1", done, valid, busy);
    end
  endtask

  task automatic test_single_next();
    repeat (2) begin
      step();
      tests++;
      if (valid !== 1'b1 || bias_out !== 32'h10) begin
        fails++;
        $display("[TB] FAIL idle_hold: got valid=%b bias=%h required 1/10", valid, bias_out);
      end
    end
    next = 1'b1; step(); next = 1'b0;
    tests++;
    if (valid !== 1'b1 || bias_out !== 32'h11) begin
      fails++;
      $display("[TB] FAIL single_next: got valid=%b bias=%h required 1/11", valid, bias_out);
    end
    tests++;
    if (cen !== 1'b0 || addr !== 9'd2) begin
      fails++;
      $display("[TB] FAIL single_read: got cen=%b addr=%0d required 0/2", cen, addr);
    end
    repeat (4) begin
      step();
      tests++;
      if (valid !== 1'b1 || bias_out !== 32'h11 || cen !== 1'b1) begin
        fails++;
        $display("[TB] FAIL single_hold: got valid=%b bias=%h cen=%b required 1/11/1", valid, bias_out, cen);
      end
    end
    tests++;
    if (rd_q.size() != 3 || rd_q[2] != 2) begin
      fails++;
      $display("[TB] FAIL single_reads: got %0d reads required 3 ending at addr 2", rd_q.size());
    end
    next = 1'b1; step(); next = 1'b0;
    tests++;
    if (valid !== 1'b1 || bias_out !== 32'h12) begin
      fails++;
      $display("[TB] FAIL second_next: got valid=%b bias=%h required 1/12", valid, bias_out);
    end
  endtask

  task automatic test_back_to_back();
    int idx, gap, target, le_cnt, exp_reads, exp_gap;
    bit acc, bad;
    do_reset(); preload_fixed();
    start = 1'b1; step(); start = 1'b0;
    wait_done();
    next = 1'b1; idx = 0; gap = 0; le_cnt = 0;
    target = WRAP ? 3 * LEN : LEN;
    for (int cyc = 0; cyc < 40 && idx < target; cyc++) begin
      acc = valid;
      if (acc) begin
        tests++;
        if (bias_out !== mem[idx % LEN]) begin
          fails++;
          $display("[TB] FAIL b2b_word%0d: got %h required %h", idx, bias_out, mem[idx % LEN]);
        end
        if (idx > 0 && idx < LEN) begin
          exp_gap = (idx == 2) ? 1 : 0;
          tests++;
          if (gap != exp_gap) begin
            fails++;
            $display("[TB] FAIL b2b_gap%0d: got %0d invalid cycles required %0d", idx, gap, exp_gap);
          end
        end
        gap = 0;
      end else begin
        gap++;
      end
      step();
      tests++;
      if (layer_end !== (acc && (idx % LEN == LEN - 1))) begin
        fails++;
        $display("[TB] FAIL b2b_layer_end%0d: got %b required %b", idx, layer_end, acc && (idx % LEN == LEN - 1));
      end
      if (layer_end === 1'b1) le_cnt++;
      if (acc) idx++;
`ifdef BIAS_RD_WRAP_EN
      tests++;
      if (busy !== 1'b1) begin
        fails++;
        $display("[TB] FAIL b2b_busy_wrap: got %b required 1", busy);
      end
`endif
    end
    tests++;
    if (idx != target) begin
      fails++;
      $display("[TB] FAIL b2b_count: got %0d words required %0d", idx, target);
    end
`ifdef BIAS_RD_WRAP_EN
    tests++;
    if (le_cnt != 3) begin
      fails++;
      $display("[TB] FAIL b2b_le_count: got %0d required 3", le_cnt);
    end
    exp_reads = 2 + target;
`else
    tests++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL b2b_end: got busy=%b valid=%b required 0/0", busy, valid);
    end
    repeat (3) begin
      step();
      tests++;
      if (cen !== 1'b1 || busy !== 1'b0 || valid !== 1'b0) begin
        fails++;
        $display("[TB] FAIL b2b_idle: got cen=%b busy=%b valid=%b required 1/0/0", cen, busy, valid);
      end
    end
    exp_reads = LEN;
`endif
    next = 1'b0;
    bad = (rd_q.size() != exp_reads);
    for (int i = 0; i < rd_q.size(); i++) if (rd_q[i] != i % LEN) bad = 1'b1;
    tests++;
    if (bad) begin
      fails++;
      $display("[TB] FAIL b2b_reads: got %0d reads required %0d in order 0..%0d", rd_q.size(), exp_reads, LEN - 1);
    end
  endtask

  task automatic test_ignore();
    do_reset(); preload_fixed();
    start = 1'b1; next = 1'b1;
    step(); step(); step();
    next = 1'b0;
    tests++;
    if (done !== 1'b1 || valid !== 1'b1 || bias_out !== 32'h10) begin
      fails++;
      $display("[TB] FAIL ign_first: got done=%b valid=%b bias=%h required 1/1/10", done, valid, bias_out);
    end
    repeat (5) begin
      step();
      tests++;
      if ({busy, done, valid, layer_end, cen} !== 5'b10101 || bias_out !== 32'h10) begin
        fails++;
        $display("[TB] FAIL ign_hold: got %b bias=%h required 10101 bias=10",
                 {busy, done, valid, layer_end, cen}, bias_out);
      end
    end
    start = 1'b0;
    tests++;
    if (rd_q.size() != 2) begin
      fails++;
      $display("[TB] FAIL ign_reads: got %0d reads required 2", rd_q.size());
    end
    next = 1'b1; step(); next = 1'b0;
    tests++;
    if (valid !== 1'b1 || bias_out !== 32'h11) begin
      fails++;
      $display("[TB] FAIL ign_next: got valid=%b bias=%h required 1/11", valid, bias_out);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(); preload_fixed();
    start = 1'b1; step(); start = 1'b0;
    wait_done();
    step(); step();
    next = 1'b1; step(); next = 1'b0;
    tests++;
    if (bias_out !== 32'h11) begin
      fails++;
      $display("[TB] FAIL mid_pre: got bias=%h required 11", bias_out);
    end
    reset = 1'b1; step();
    tests++;
    if ({busy, done, valid, layer_end, cen, wen} !== 6'b000011 || addr !== '0 || bias_out !== '0) begin
      fails++;
      $display("[TB] FAIL mid_reset: got %b addr=%h bias=%h required 000011/0/0",
               {busy, done, valid, layer_end, cen, wen}, addr, bias_out);
    end
    reset = 1'b0; step();
    tests++;
    if ({busy, done, valid, layer_end, cen} !== 5'b00001) begin
      fails++;
      $display("[TB] FAIL mid_quiet: got %b required 00001", {busy, done, valid, layer_end, cen});
    end
    test_first_read();
  endtask

  task automatic test_random();
    int consumed, lowrun, passes, exp_reads;
    bit acc, a1, a2, done_pass, bad;
    do_reset();
    for (int i = 0; i < LEN; i++) mem[i] = $urandom;
    passes = WRAP ? 1 : 3;
    for (int p = 0; p < passes; p++) begin
      rd_q.delete();
      start = 1'b1; step(); start = 1'b0;
      wait_done();
      consumed = 0; a1 = 1'b0; a2 = 1'b0; lowrun = 0; done_pass = 1'b0;
      for (int cyc = 0; cyc < 120 && !done_pass; cyc++) begin
        next = ($urandom_range(0, 2) != 0);
        acc = next && (valid === 1'b1);
        if (acc) begin
          tests++;
          if (bias_out !== mem[consumed % LEN]) begin
            fails++;
            $display("[TB] FAIL rnd_word%0d: got %h required %h", consumed, bias_out, mem[consumed % LEN]);
          end
        end
        lowrun = (valid === 1'b1) ? 0 : lowrun + 1;
        if (lowrun > 2) begin
          tests++; fails++;
          $display("[TB] FAIL rnd_stall: got valid low %0d cycles required at most 2", lowrun);
          done_pass = 1'b1;
        end
        step();
        tests++;
        if (layer_end !== (acc && (consumed % LEN == LEN - 1))) begin
          fails++;
          $display("[TB] FAIL rnd_layer_end%0d: got %b required %b", consumed, layer_end,
                   acc && (consumed % LEN == LEN - 1));
        end
        tests++;
        if (wen !== 1'b1) begin
          fails++;
          $display("[TB] FAIL rnd_wen: got %b required 1", wen);
        end
        if (acc && !a1 && !a2 && (WRAP || (consumed % LEN != LEN - 1))) begin
          tests++;
          if (valid !== 1'b1) begin
            fails++;
            $display("[TB] FAIL rnd_isolated%0d: got valid=%b required 1", consumed, valid);
          end
        end
        a2 = a1; a1 = acc;
        if (acc) consumed++;
`ifndef BIAS_RD_WRAP_EN
        if (consumed == LEN) begin
          done_pass = 1'b1;
          tests++;
          if (busy !== 1'b0 || valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL rnd_end: got busy=%b valid=%b required 0/0", busy, valid);
          end
        end
`endif
      end
      next = 1'b0;
      exp_reads = WRAP ? 2 + consumed : ((2 + consumed < LEN) ? 2 + consumed : LEN);
      bad = (rd_q.size() != exp_reads);
      for (int i = 0; i < rd_q.size(); i++) if (rd_q[i] != i % LEN) bad = 1'b1;
      tests++;
      if (bad) begin
        fails++;
        $display("[TB] FAIL rnd_reads: got %0d reads required %0d in address order", rd_q.size(), exp_reads);
      end
`ifndef BIAS_RD_WRAP_EN
      tests++;
      if (consumed != LEN) begin
        fails++;
        $display("[TB] FAIL rnd_pass%0d: got %0d words required %0d", p, consumed, LEN);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_first_read();
    test_single_next();
    test_back_to_back();
    test_ignore();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
